// File: rtl/tdm_demux16_if.sv
// tdm_demux16_if
// Bundles the serial-in / parallel-out signals of the 16-lane TDM
// demultiplexer. Clock and reset stay outside as plain ports.
//
//   start  : frame-sync pulse, arms a new frame at slot 0
//   en     : data-valid qualifier for d
//   d      : serial data bit for the current slot
//   w      : last completed frame, w[k] is the bit received in slot k
//   valid  : one-cycle pulse, w was updated at the preceding edge
//   busy   : high while a frame is being received
//   s      : next slot index to be written
//   err    : one-cycle pulse when a frame is aborted by start
//
// master drives the serial side; slave is the demultiplexer.
interface tdm_demux16_if;
  logic        start;
  logic        en;
  logic        d;
  logic [0:15] w;
  logic        valid;
  logic        busy;
  logic [3:0]  s;
  logic        err;

  modport master (
    output start, en, d,
    input  w, valid, busy, s, err
  );

  modport slave (
    input  start, en, d,
    output w, valid, busy, s, err
  );
endinterface

// File: rtl/tdm_demux16.sv
// tdm_demux16
// Serial time-division demultiplexer. Rebuilds a 16-bit word w[0:15]
// from a 1-bit stream, one slot per accepted bit, in the same index
// order a 16:1 mux transmitter steps through. A completed frame is
// copied to the output register w with a one-cycle valid strobe.
//
// Ports:
//   Clock : single clock, all state updates on the rising edge
//   Reset : synchronous, active-high reset
//   bus   : tdm_demux16_if.slave (start, en, d in; w, valid, busy, s, err out)
module tdm_demux16 (
  input  logic              Clock,
  input  logic              Reset,
  tdm_demux16_if.slave      bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  slot;
  logic [3:0]  slot_next;
  logic [0:15] sh;
  logic [0:15] sh_next;
  logic [0:15] word;
  logic [0:15] word_next;
  logic        valid_q;
  logic        valid_next;
  logic        err_q;
  logic        err_next;

  // State and datapath registers. Reset wins over every input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      slot    <= 4'd0;
      sh      <= '0;
      word    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      slot    <= slot_next;
      sh      <= sh_next;
      word    <= word_next;
      valid_q <= valid_next;
      err_q   <= err_next;
    end
  end

  // Next-state and datapath logic. Everything holds by default and the
  // strobes default low so each one lasts a single cycle.
  // In RECV, start outranks en: an abort restarts the frame at slot 0
  // and drops the partial shadow contents while leaving w alone.
  // The last bit goes straight into lane 15 of w together with the
  // shadow lanes 0..14, so the frame appears at the same edge it ends.
  always_comb begin
    state_next = state;
    slot_next  = slot;
    sh_next    = sh;
    word_next  = word;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RECV;
          slot_next  = 4'd0;
          sh_next    = '0;
        end
      end

      RECV: begin
        if (bus.start) begin
          slot_next = 4'd0;
          sh_next   = '0;
          err_next  = 1'b1;
        end else if (bus.en) begin
          sh_next[slot] = bus.d;
          if (slot == 4'd15) begin
            word_next  = {sh[0:14], bus.d};
            valid_next = 1'b1;
            state_next = IDLE;
            slot_next  = 4'd0;
          end else begin
            slot_next = slot + 4'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        slot_next  = 4'd0;
      end
    endcase
  end

  assign bus.w     = word;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.s     = slot;
  assign bus.busy  = (state == RECV);

endmodule
